// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register:
// FSM encodings, NOP/zero constants and per-stage payload field offsets.
package pipe_skid_stage_pkg;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [ST_W-1:0] ST_BUSY  = 2'd1;
   localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

   localparam int unsigned NOP_RD_W = 5;
   localparam int unsigned ZERO_W   = 64;

   localparam logic [NOP_RD_W-1:0] NopRegAddr = 5'd0;
   localparam logic [ZERO_W-1:0]   Zero       = 64'd0;

   // IF/ID payload: {instr, pc}
   localparam int unsigned IFID_PC_LSB     = 0;
   localparam int unsigned IFID_PC_W       = 32;
   localparam int unsigned IFID_INSTR_LSB  = 32;
   localparam int unsigned IFID_INSTR_W    = 32;

   // ID/EX payload: {ctl, imm, opb, opa}
   localparam int unsigned IDEX_OPA_LSB    = 0;
   localparam int unsigned IDEX_OPA_W      = 16;
   localparam int unsigned IDEX_OPB_LSB    = 16;
   localparam int unsigned IDEX_OPB_W      = 16;
   localparam int unsigned IDEX_IMM_LSB    = 32;
   localparam int unsigned IDEX_IMM_W      = 24;
   localparam int unsigned IDEX_CTL_LSB    = 56;
   localparam int unsigned IDEX_CTL_W      = 8;

   // EX/MEM payload: {ls_ctl, storedata, result}
   localparam int unsigned EXMEM_RES_LSB   = 0;
   localparam int unsigned EXMEM_RES_W     = 32;
   localparam int unsigned EXMEM_SD_LSB    = 32;
   localparam int unsigned EXMEM_SD_W      = 28;
   localparam int unsigned EXMEM_LSCTL_LSB = 60;
   localparam int unsigned EXMEM_LSCTL_W   = 4;

   // MEM/WB payload: {wb_sel, loaddata, result}
   localparam int unsigned MEMWB_RES_LSB   = 0;
   localparam int unsigned MEMWB_RES_W     = 32;
   localparam int unsigned MEMWB_LD_LSB    = 32;
   localparam int unsigned MEMWB_LD_W      = 31;
   localparam int unsigned MEMWB_SEL_LSB   = 63;
   localparam int unsigned MEMWB_SEL_W     = 1;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, NOP-masked bypass view and perf counters.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RD_W   = 5,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cnt_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_regwe,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_regwe,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(Zero);
   localparam logic [RD_W-1:0]   RD_NOP    = RD_W'(NopRegAddr);

   logic [ST_W-1:0]   state, state_nxt;
   logic [DATA_W-1:0] main_data, main_data_nxt;
   logic [RD_W-1:0]   main_rd, main_rd_nxt;
   logic              main_regwe, main_regwe_nxt;
   logic [DATA_W-1:0] skid_data, skid_data_nxt;
   logic [RD_W-1:0]   skid_rd, skid_rd_nxt;
   logic              skid_regwe, skid_regwe_nxt;
   logic              acc, rel;

   assign acc = in_valid & in_ready;
   assign rel = out_valid & out_ready;

   // Cleared entries always read as a NOP so the bypass view stays safe.
   assign out_data  = main_data;
   assign out_rd    = main_rd;
   assign out_regwe = main_regwe;

   // State and payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         out_valid  <= 1'b0;
         main_data  <= DATA_ZERO;
         main_rd    <= RD_NOP;
         main_regwe <= 1'b0;
         skid_data  <= DATA_ZERO;
         skid_rd    <= RD_NOP;
         skid_regwe <= 1'b0;
      end else begin
         state      <= state_nxt;
         out_valid  <= (state_nxt != ST_EMPTY);
         main_data  <= main_data_nxt;
         main_rd    <= main_rd_nxt;
         main_regwe <= main_regwe_nxt;
         skid_data  <= skid_data_nxt;
         skid_rd    <= skid_rd_nxt;
         skid_regwe <= skid_regwe_nxt;
      end
   end

   // Next-state and entry update
   always_comb begin
      state_nxt      = state;
      main_data_nxt  = main_data;
      main_rd_nxt    = main_rd;
      main_regwe_nxt = main_regwe;
      skid_data_nxt  = skid_data;
      skid_rd_nxt    = skid_rd;
      skid_regwe_nxt = skid_regwe;

      if (flush) begin
         state_nxt      = ST_EMPTY;
         main_data_nxt  = DATA_ZERO;
         main_rd_nxt    = RD_NOP;
         main_regwe_nxt = 1'b0;
         skid_data_nxt  = DATA_ZERO;
         skid_rd_nxt    = RD_NOP;
         skid_regwe_nxt = 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  state_nxt      = ST_BUSY;
                  main_data_nxt  = in_data;
                  main_rd_nxt    = in_rd;
                  main_regwe_nxt = in_regwe;
               end
            end
            ST_BUSY: begin
               if (acc && rel) begin
                  main_data_nxt  = in_data;
                  main_rd_nxt    = in_rd;
                  main_regwe_nxt = in_regwe;
               end else if (acc) begin
                  // Without a skid buffer in_ready already implies rel here.
                  if (SKID != 0) begin
                     state_nxt      = ST_FULL;
                     skid_data_nxt  = in_data;
                     skid_rd_nxt    = in_rd;
                     skid_regwe_nxt = in_regwe;
                  end
               end else if (rel) begin
                  state_nxt      = ST_EMPTY;
                  main_data_nxt  = DATA_ZERO;
                  main_rd_nxt    = RD_NOP;
                  main_regwe_nxt = 1'b0;
               end
            end
            ST_FULL: begin
               if (rel) begin
                  state_nxt      = ST_BUSY;
                  main_data_nxt  = skid_data;
                  main_rd_nxt    = skid_rd;
                  main_regwe_nxt = skid_regwe;
                  skid_data_nxt  = DATA_ZERO;
                  skid_rd_nxt    = RD_NOP;
                  skid_regwe_nxt = 1'b0;
               end
            end
            default: begin
               state_nxt      = ST_EMPTY;
               main_data_nxt  = DATA_ZERO;
               main_rd_nxt    = RD_NOP;
               main_regwe_nxt = 1'b0;
               skid_data_nxt  = DATA_ZERO;
               skid_rd_nxt    = RD_NOP;
               skid_regwe_nxt = 1'b0;
            end
         endcase
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic ready_q;

         // Registered ready: low exactly while the skid entry is occupied.
         always_ff @(posedge clk) begin
            if (rst) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (state_nxt != ST_FULL);
            end
         end

         assign in_ready = ready_q;
      end else begin : g_noskid
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .clr   (cnt_clr),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~out_valid),
      .clr   (cnt_clr),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three builds (skid/16-bit, no-skid, skid/4-bit counters)
// share one stimulus stream and are checked against a FIFO-occupancy model.
module tb_pipe_skid_stage;

   logic        clk = 1'b0;
   logic        rst, flush, cnt_clr, in_valid, in_regwe, out_ready;
   logic [63:0] in_data;
   logic [4:0]  in_rd;

   logic        a_ir, a_ov, a_we, b_ir, b_ov, b_we, c_ir, c_ov, c_we;
   logic [63:0] a_d, b_d, c_d;
   logic [4:0]  a_rd, b_rd, c_rd;
   logic [15:0] a_st, a_bu, b_st, b_bu;
   logic [3:0]  c_st, c_bu;

   int n_cmp = 0;
   int n_err = 0;
   bit started = 1'b0;

   // Model: per build, an in-order FIFO of held beats (capacity 2 or 1) plus counters.
   int          mskid [3] = '{1, 0, 1};
   int          mmax  [3] = '{65535, 65535, 15};
   int          mn    [3] = '{0, 0, 0};
   int          mst   [3] = '{0, 0, 0};
   int          mbu   [3] = '{0, 0, 0};
   logic [63:0] mdat  [3][2];
   logic [4:0]  mrd   [3][2];
   logic        mwe   [3][2];

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(64), .RD_W(5), .SKID(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data), .in_rd(in_rd),
      .in_regwe(in_regwe), .out_valid(a_ov), .out_ready(out_ready),
      .out_data(a_d), .out_rd(a_rd), .out_regwe(a_we),
      .stall_cnt(a_st), .bubble_cnt(a_bu));

   pipe_skid_stage #(.DATA_W(64), .RD_W(5), .SKID(0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data), .in_rd(in_rd),
      .in_regwe(in_regwe), .out_valid(b_ov), .out_ready(out_ready),
      .out_data(b_d), .out_rd(b_rd), .out_regwe(b_we),
      .stall_cnt(b_st), .bubble_cnt(b_bu));

   pipe_skid_stage #(.DATA_W(64), .RD_W(5), .SKID(1), .CNT_W(4)) u_c (
      .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data), .in_rd(in_rd),
      .in_regwe(in_regwe), .out_valid(c_ov), .out_ready(out_ready),
      .out_data(c_d), .out_rd(c_rd), .out_regwe(c_we),
      .stall_cnt(c_st), .bubble_cnt(c_bu));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic model_ready(input int k);
      if (mskid[k] != 0) return (mn[k] < 2);
      return (mn[k] == 0) || out_ready;
   endfunction

   // Advance the model on each rising edge using the pre-edge occupancy.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic ir, ov;
         ir = model_ready(k);
         ov = (mn[k] > 0);
         if (rst) begin
            mn[k] = 0; mst[k] = 0; mbu[k] = 0;
         end else begin
            if (cnt_clr) begin
               mst[k] = 0; mbu[k] = 0;
            end else begin
               if (ov && !out_ready && mst[k] < mmax[k]) mst[k]++;
               if (!ov && mbu[k] < mmax[k]) mbu[k]++;
            end
            if (flush) begin
               mn[k] = 0;
            end else begin
               if (ov && out_ready) begin
                  mdat[k][0] = mdat[k][1]; mrd[k][0] = mrd[k][1]; mwe[k][0] = mwe[k][1];
                  mn[k]--;
               end
               if (in_valid && ir) begin
                  mdat[k][mn[k]] = in_data; mrd[k][mn[k]] = in_rd; mwe[k][mn[k]] = in_regwe;
                  mn[k]++;
               end
            end
         end
      end
   end

   task automatic cmp_inst(input int k, input logic ov, input logic ir, input logic [63:0] d,
                           input logic [4:0] r, input logic w, input logic [15:0] st,
                           input logic [15:0] bu);
      logic        e_ov;
      logic [63:0] e_d;
      logic [4:0]  e_r;
      logic        e_w;
      e_ov = (mn[k] > 0);
      e_d  = e_ov ? mdat[k][0] : 64'd0;
      e_r  = e_ov ? mrd[k][0]  : 5'd0;
      e_w  = e_ov ? mwe[k][0]  : 1'b0;
      check($sformatf("m%0d.out_valid", k), 64'(ov), 64'(e_ov));
      check($sformatf("m%0d.in_ready", k),  64'(ir), 64'(model_ready(k)));
      check($sformatf("m%0d.out_data", k),  d, e_d);
      check($sformatf("m%0d.out_rd", k),    64'(r), 64'(e_r));
      check($sformatf("m%0d.out_regwe", k), 64'(w), 64'(e_w));
      check($sformatf("m%0d.stall_cnt", k), 64'(st), 64'(mst[k]));
      check($sformatf("m%0d.bubble_cnt", k), 64'(bu), 64'(mbu[k]));
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp_inst(0, a_ov, a_ir, a_d, a_rd, a_we, a_st, a_bu);
         cmp_inst(1, b_ov, b_ir, b_d, b_rd, b_we, b_st, b_bu);
         cmp_inst(2, c_ov, c_ir, c_d, c_rd, c_we, 16'(c_st), 16'(c_bu));
      end
   end

   task automatic drive(input logic iv, input logic [63:0] d, input logic [4:0] r,
                        input logic w, input logic ordy, input logic fl, input logic clr);
      in_valid = iv; in_data = d; in_rd = r; in_regwe = w;
      out_ready = ordy; flush = fl; cnt_clr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      started = 1'b1;
      tick();

      // Reset then idle
      rst = 1'b0;
      repeat (3) tick();
      check("rst.out_valid", 64'(a_ov), 64'd0);
      check("rst.out_rd", 64'(a_rd), 64'd0);
      check("rst.out_regwe", 64'(a_we), 64'd0);
      check("rst.in_ready", 64'(a_ir), 64'd1);
      check("rst.bubble_cnt", 64'(a_bu), 64'd3);
      check("rst.stall_cnt", 64'(a_st), 64'd0);

      // Back-to-back streaming
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 64'h10 + 64'(i), 5'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
         check("stream.out_rd", 64'(a_rd), 64'(i + 1));
         check("stream.out_data", a_d, 64'h10 + 64'(i));
         check("stream.in_ready", 64'(a_ir), 64'd1);
      end
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("stream.drained", 64'(a_ov), 64'd0);
      check("stream.stall_cnt", 64'(a_st), 64'd0);

      // Backpressure into the skid entry
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 64'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h44, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp.in_ready", 64'(a_ir), 64'd0);
      check("bp.out_rd", 64'(a_rd), 64'd3);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check("bp.held_rd", 64'(a_rd), 64'd3);
      check("bp.stall_cnt", 64'(a_st), 64'd4);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("bp.second_rd", 64'(a_rd), 64'd4);
      check("bp.second_data", a_d, 64'h44);
      check("bp.in_ready_back", 64'(a_ir), 64'd1);
      tick();
      check("bp.empty", 64'(a_ov), 64'd0);

      // Flush while full with a beat offered in the same cycle
      drive(1'b1, 64'h55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h66, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("fl.full", 64'(a_ir), 64'd0);
      drive(1'b1, 64'h77, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("fl.out_valid", 64'(a_ov), 64'd0);
      check("fl.out_regwe", 64'(a_we), 64'd0);
      check("fl.out_rd", 64'(a_rd), 64'd0);
      check("fl.out_data", a_d, 64'd0);
      check("fl.in_ready", 64'(a_ir), 64'd1);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) tick();
      check("fl.no_rd7", 64'(a_ov), 64'd0);

      // No-skid build: combinational ready and bubble-free replace
      drive(1'b1, 64'h99, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("ns.out_rd", 64'(b_rd), 64'd9);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("ns.ready_low", 64'(b_ir), 64'd0);
      drive(1'b1, 64'hAA, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      check("ns.ready_high", 64'(b_ir), 64'd1);
      tick();
      check("ns.replace_valid", 64'(b_ov), 64'd1);
      check("ns.replace_rd", 64'(b_rd), 64'd10);
      check("ns.replace_data", b_d, 64'hAA);
      check("ns.regwe_masked", 64'(b_we), 64'd0);

      // Counter saturation with 4-bit counters, then clear and resume
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hBB, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (20) tick();
      check("sat.stall_c", 64'(c_st), 64'd15);
      check("sat.stall_a", 64'(a_st), 64'd20);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("sat.cleared", 64'(c_st), 64'd0);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("sat.resume", 64'(c_st), 64'd1);
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();

      // Reset while full drops both beats
      drive(1'b1, 64'hC1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hC2, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      check("rstfull.out_valid", 64'(a_ov), 64'd0);
      check("rstfull.in_ready", 64'(a_ir), 64'd1);
      check("rstfull.stall_cnt", 64'(a_st), 64'd0);
      repeat (2) tick();
      check("rstfull.dropped", 64'(a_ov), 64'd0);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the global stall-vector protocol with a per-stage valid/ready handshake.
- Adds an optional 2-entry skid buffer so in_ready is registered, a synchronous flush, and a NOP-masked bypass view (rd/regwe).
- Adds saturating stall and bubble counters for performance analysis.

Parameters:
- DATA_W, 64: width of opaque payload (result, storedata, load/store ctl, packed by the instantiating stage).
- RD_W, 5: destination register address width.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous squash of all held and incoming beats.
- cnt_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_rd  in  RD_W  upstream destination register.
- in_regwe  in  1  upstream register write enable.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main entry payload; zero when not valid.
- out_rd  out  RD_W  main entry rd; zero when not valid.
- out_regwe  out  1  main regwe AND out_valid; this is the forwarding-safe NOP view.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.

Behaviour:
Handshake
- acc = in_valid & in_ready; rel = out_valid & out_ready.
- The upstream side must hold in_data, in_rd and in_regwe stable while in_valid=1 and in_ready=0.
- Latency is 1 cycle: a beat accepted into an empty stage appears on out_* at the next edge.

States
- EMPTY: main invalid, skid invalid.
- BUSY: main valid, skid invalid.
- FULL: main valid, skid valid. Reachable only when SKID=1.

in_ready
- SKID=1: in_ready = !skid_valid (a register output).
- SKID=0: in_ready = !out_valid | out_ready.

Transitions (evaluated only when rst=0 and flush=0)
- EMPTY: acc -> main <= in, go to BUSY. Otherwise stay in EMPTY.
- BUSY with acc and rel: main <= in, stay in BUSY.
- BUSY with acc and no rel (SKID=1): skid <= in, go to FULL.
- BUSY with rel and no acc: clear main, go to EMPTY.
- BUSY with neither: hold.
- FULL with rel: main <= skid, clear skid, go to BUSY. No acc is possible because in_ready=0.
- FULL without rel: hold.

Ordering and zeroing
- Order is strictly FIFO: a skid beat always drains before any newer beat.
- A cleared entry has all payload fields set to zero: data=0, rd=0, regwe=0.

Flush
- Priority: rst, then flush, then normal transitions.
- flush=1 forces EMPTY and zeroes both entries.
- An acc in the same cycle is discarded.
- in_ready in the flush cycle follows its normal rule; the upstream side treats the beat as consumed.
- out_* is zero on the next edge.

Reset
- rst=1 forces EMPTY.
- All payload is zero; in_ready=1 on the next cycle; out_valid=0; out_rd=0; out_regwe=0; out_data=0.
- Both counters are cleared.
- rst asserted while FULL drops both beats.

Counters
- Priority per cycle: rst, then cnt_clr, then increment.
- Counters increment on the conditions above and saturate at 2^CNT_W-1; they never wrap.
- flush does not clear the counters.
- The flush cycle itself is counted according to the pre-flush out_valid.

Decomposition:
- Shared package / define header:
  - State encodings ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - Existing NopRegAddr and Zero constants.
  - Payload-packing field offsets for each stage's DATA_W layout.
- Sub-module sat_counter (width CNT_W; ports inc, clr, count).
  - Instantiated twice for stall_cnt and bubble_cnt.
- Datapath and FSM stay in pipe_skid_stage.

Test Plan:
- Reset/idle: rst for 2 cycles, then idle 3 cycles -> out_valid=0, out_rd=0, out_regwe=0, in_ready=1, bubble_cnt=3, stall_cnt=0.
- Streaming: out_ready=1 held; send rd=1..8, data=0x10..0x17, regwe=1 back to back -> each beat appears 1 cycle later, in order, in_ready stays 1, stall_cnt=0.
- Backpressure with SKID=1: send rd=3, then rd=4 with out_ready=0 for 4 cycles -> in_ready=0 from the cycle after rd=4 is accepted. out_rd=3 held, stall_cnt=4. After out_ready=1, the order is 3 then 4.
- Flush while FULL, with in_valid=1 carrying rd=7 -> next cycle out_valid=0, out_regwe=0, out_rd=0. rd=7 never appears. in_ready=1.
- SKID=0 build: out_ready=0 with main valid -> in_ready=0 in the same cycle. Raise out_ready=1 with in_valid=1 -> new beat replaces the old one at the edge with no bubble.
- Saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15. cnt_clr for 1 cycle -> 0, then resumes counting.
